jk_stim_gen: RTL and testbench

//  Drive side of the JK flip-flop interface: turns target Q patterns into JK commands.

---
 rtl/jk_stim_gen.sv | 134 +++++++++++++
 tb/tb_jk_stim_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_stim_gen.sv
// jk_stim_gen
//    Stimulus and checker for a JK flip-flop under test. It takes WIDTH-bit words of
//    target Q values on a valid/ready handshake and applies them MSB first. Each bit
//    takes two cycles: a DRIVE cycle that presents the JK excitation for the move from
//    the tracked Q to the target bit, then a CHECK cycle that holds JK=00 and compares
//    the returned Q against the tracked value.
//
// Ports
//    CLK        clock, rising edge
//    RESET      asynchronous reset, active low
//    pat_valid  target word offered
//    pat_data   target word, bit WIDTH-1 applied first
//    pat_ready  word can be accepted (IDLE only)
//    JK         {J,K} to the flip-flop under test
//    q_fb       Q returned by the flip-flop under test
//    q_model    expected Q of the flip-flop under test
//    busy       word in progress
//    done       one-cycle pulse after the last bit is checked
//    err_clr    synchronous clear of err_cnt, wins over an increment
//    err_cnt    saturating mismatch count, kept across words
//
// Build option
//    JK_TOGGLE_EN  defined: every state change is driven as JK=11 (toggle).
//                  undefined: 0->1 is driven as 10 (set), 1->0 as 01 (reset).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a word, pat_ready=1
// S_DRIVE | JK excitation for the current bit on the pins
// S_CHECK | JK=00, q_fb compared with q_model, then next bit or IDLE

module jk_stim_gen #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             pat_valid,
   input  logic [WIDTH-1:0] pat_data,
   output logic             pat_ready,
   output logic [1:0]       JK,
   input  logic             q_fb,
   output logic             q_model,
   output logic             busy,
   output logic             done,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] ERR_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [BC_W-1:0]  bit_cnt;

   // JK needed to move the flip-flop from q to t on the next edge.
   function automatic logic [1:0] excite(input logic q, input logic t);
      logic [1:0] jk;
      jk = 2'b00;
      if (q != t) begin
`ifdef JK_TOGGLE_EN
         jk = 2'b11;
`else
         jk = t ? 2'b10 : 2'b01;
`endif
      end
      return jk;
   endfunction

   assign pat_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state   <= S_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         JK      <= 2'b00;
         q_model <= 1'b0;
         done    <= 1'b0;
         err_cnt <= '0;
      end else begin
         done <= 1'b0;

         if (err_clr)
            err_cnt <= '0;
         else if (state == S_CHECK && q_fb != q_model && err_cnt != ERR_MAX)
            err_cnt <= err_cnt + 1'b1;

         case (state)
            S_IDLE: begin
               JK <= 2'b00;
               if (pat_valid) begin
                  shreg   <= pat_data;
                  bit_cnt <= BC_W'(WIDTH - 1);
                  // JK is registered, so the first excitation is loaded on the
                  // accepting edge to appear in the first DRIVE cycle.
                  JK      <= excite(q_model, pat_data[WIDTH-1]);
                  state   <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               q_model <= shreg[WIDTH-1];
               JK      <= 2'b00;
               state   <= S_CHECK;
            end
            S_CHECK: begin
               if (bit_cnt == '0) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  bit_cnt <= bit_cnt - BC_W'(1);
                  shreg   <= shreg << 1;
                  // q_model already holds the bit just applied.
                  JK      <= excite(q_model, shreg[WIDTH-2]);
                  state   <= S_DRIVE;
               end
            end
            default: begin
               JK    <= 2'b00;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_stim_gen.sv
module tb_jk_stim_gen;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 8;
   localparam int ERR_MAX = (1 << CNT_W) - 1;

   logic             CLK = 1'b0;
   logic             RESET;
   logic             pat_valid;
   logic [WIDTH-1:0] pat_data;
   logic             pat_ready;
   logic [1:0]       JK;
   logic             q_fb;
   logic             q_model;
   logic             busy;
   logic             done;
   logic             err_clr;
   logic [CNT_W-1:0] err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // 0 ideal flip-flop, 1 stuck at 0, 2 stuck at 1, 3 inverted
   int   fb_mode = 0;
   logic q_ff;

   // reference state: Q of the flip-flop and expected error count
   bit exp_q   = 1'b0;
   int exp_err = 0;

   always #5 CLK = ~CLK;

   jk_stim_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .pat_valid (pat_valid),
      .pat_data  (pat_data),
      .pat_ready (pat_ready),
      .JK        (JK),
      .q_fb      (q_fb),
      .q_model   (q_model),
      .busy      (busy),
      .done      (done),
      .err_clr   (err_clr),
      .err_cnt   (err_cnt)
   );

   // behavioural synchronous JK flip-flop under test, sharing RESET
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) q_ff <= 1'b0;
      else begin
         case (JK)
            2'b01:   q_ff <= 1'b0;
            2'b10:   q_ff <= 1'b1;
            2'b11:   q_ff <= ~q_ff;
            default: q_ff <= q_ff;
         endcase
      end
   end

   always_comb begin
      q_fb = q_ff;
      case (fb_mode)
         1:       q_fb = 1'b0;
         2:       q_fb = 1'b1;
         3:       q_fb = ~q_ff;
         default: q_fb = q_ff;
      endcase
   end

   // JK excitation table of a JK flip-flop
   function automatic logic [1:0] exp_jk(input bit q, input bit t);
      if (q == t) return 2'b00;
`ifdef JK_TOGGLE_EN
      return 2'b11;
`else
      return t ? 2'b10 : 2'b01;
`endif
   endfunction

   // does the fault mode make the returned Q differ from target t
   function automatic bit mism(input bit t);
      case (fb_mode)
         1:       return t == 1'b1;
         2:       return t == 1'b0;
         3:       return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Offers one word (entered just after a negedge) and checks every cycle until done.
   task automatic run_word(input logic [WIDTH-1:0] data, input bit hold_valid,
                           input logic [WIDTH-1:0] next_data, input int clr_cyc);
      int waited;
      bit t;
      waited = 0;
      pat_data  = data;
      pat_valid = 1'b1;
      while (pat_ready !== 1'b1 && waited < 50) begin
         @(negedge CLK);
         waited++;
      end
      n_checks++;
      if (pat_ready !== 1'b1) begin
         n_fail++; $display("FAIL accept_ready: pat_ready=%b expected 1", pat_ready);
      end
      for (int c = 1; c <= 2 * WIDTH; c++) begin
         @(negedge CLK);
         err_clr = 1'b0;
         if (hold_valid) pat_data = next_data;
         else begin
            pat_valid = 1'(($urandom_range(0, 1)));
            pat_data  = WIDTH'($urandom);
         end
         t = data[WIDTH - 1 - (c - 1) / 2];
         n_checks++;
         if (err_cnt !== CNT_W'(exp_err)) begin
            n_fail++; $display("FAIL err_cnt c=%0d: got %0d expected %0d", c, err_cnt, exp_err);
         end
         n_checks++;
         if (busy !== 1'b1 || pat_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL busy_flags c=%0d: busy=%b ready=%b done=%b expected 1 0 0",
                               c, busy, pat_ready, done);
         end
         if (c % 2 == 1) begin
            n_checks++;
            if (JK !== exp_jk(exp_q, t)) begin
               n_fail++; $display("FAIL drive_jk c=%0d: JK=%b expected %b", c, JK, exp_jk(exp_q, t));
            end
            n_checks++;
            if (q_model !== exp_q) begin
               n_fail++; $display("FAIL drive_q_model c=%0d: got %b expected %b", c, q_model, exp_q);
            end
         end else begin
            exp_q = t;
            n_checks++;
            if (JK !== 2'b00 || q_model !== exp_q) begin
               n_fail++; $display("FAIL check_cycle c=%0d: JK=%b q_model=%b expected 00 %b",
                                  c, JK, q_model, exp_q);
            end
            if (c == clr_cyc) begin
               err_clr = 1'b1;
               exp_err = 0;
            end else if (mism(t) && exp_err < ERR_MAX) exp_err++;
         end
      end
      @(negedge CLK);
      err_clr = 1'b0;
      if (!hold_valid) pat_valid = 1'b0;
      n_checks++;
      if (done !== 1'b1 || pat_ready !== 1'b1 || busy !== 1'b0 || JK !== 2'b00) begin
         n_fail++; $display("FAIL done_cycle: done=%b ready=%b busy=%b JK=%b expected 1 1 0 00",
                            done, pat_ready, busy, JK);
      end
      n_checks++;
      if (err_cnt !== CNT_W'(exp_err) || q_model !== exp_q) begin
         n_fail++; $display("FAIL word_end: err_cnt=%0d q_model=%b expected %0d %b",
                            err_cnt, q_model, exp_err, exp_q);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b0; pat_valid = 1'b0; pat_data = '0; err_clr = 1'b0; fb_mode = 0;
      #1;
      n_checks++;
      if (JK !== 2'b00 || q_model !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          pat_ready !== 1'b1 || err_cnt !== '0) begin
         n_fail++; $display("FAIL reset_state: JK=%b q=%b busy=%b done=%b ready=%b err=%0d",
                            JK, q_model, busy, done, pat_ready, err_cnt);
      end
      @(negedge CLK); @(negedge CLK);
      RESET = 1'b1;
      exp_q = 1'b0; exp_err = 0;
      @(negedge CLK);
   endtask

   task automatic test_basic();
      fb_mode = 0;
      run_word(8'b1010_0110, 1'b0, '0, 0);
   endtask

   task automatic test_stuck0();
      fb_mode = 1;
      run_word(8'b1010_0110, 1'b0, '0, 0);
      fb_mode = 0;
   endtask

   task automatic test_toggle_pattern();
      fb_mode = 0;
      run_word(8'hF0, 1'b0, '0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         fb_mode = $urandom_range(0, 3);
         run_word(WIDTH'($urandom), 1'b0, '0, 0);
      end
      fb_mode = 0;
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] w [3];
      fb_mode = 0;
      for (int i = 0; i < 3; i++) w[i] = WIDTH'($urandom);
      run_word(w[0], 1'b1, w[1], 0);
      run_word(w[1], 1'b1, w[2], 0);
      run_word(w[2], 1'b0, '0, 0);
   endtask

   task automatic test_saturation();
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;
      exp_err = 0;
      n_checks++;
      if (err_cnt !== '0) begin
         n_fail++; $display("FAIL idle_clear: err_cnt=%0d expected 0", err_cnt);
      end
      fb_mode = 3;
      for (int i = 0; i < 33; i++) run_word(WIDTH'($urandom), 1'b0, '0, 0);
      n_checks++;
      if (err_cnt !== CNT_W'(ERR_MAX)) begin
         n_fail++; $display("FAIL saturated: err_cnt=%0d expected %0d", err_cnt, ERR_MAX);
      end
      run_word(WIDTH'($urandom), 1'b0, '0, 4);
      fb_mode = 0;
   endtask

   task automatic test_reset_mid();
      fb_mode = 1;
      pat_data = 8'hFF; pat_valid = 1'b1;
      @(negedge CLK); pat_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      n_checks++;
      if (JK !== 2'b00 || q_model !== 1'b0 || busy !== 1'b0 || pat_ready !== 1'b1 ||
          err_cnt !== '0 || done !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid: JK=%b q=%b busy=%b ready=%b err=%0d done=%b",
                            JK, q_model, busy, pat_ready, err_cnt, done);
      end
      @(negedge CLK);
      RESET = 1'b1;
      exp_q = 1'b0; exp_err = 0; fb_mode = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abandoned_word: done=%b busy=%b expected 0 0", done, busy);
         end
      end
      run_word(WIDTH'($urandom), 1'b0, '0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stuck0();
      test_toggle_pattern();
      test_random();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
